// File: rtl/tagged_mem_responder_pkg.sv
// Shared bus encodings, tag types and the latency-pipe slot layout for the
// processor-to-memory responder.
package tagged_mem_responder_pkg;

  localparam int TAG_BITS = 4;
  localparam int NUM_TAGS = 15;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } mem_cmd_t;

  typedef logic [TAG_BITS-1:0] mem_tag_t;

  typedef struct packed {
    logic        valid;
    mem_tag_t    tag;
    logic [63:0] data;
  } resp_slot_t;

  // Tag 0 is reserved for "no response", so the sequence runs 1..15 and wraps.
  function automatic mem_tag_t tag_inc(input mem_tag_t t);
    return (t == mem_tag_t'(NUM_TAGS)) ? mem_tag_t'(1) : t + mem_tag_t'(1);
  endfunction

endpackage

// File: rtl/tagged_mem_responder_mem_resp_pipe.sv
// Fixed-latency shift register of load completions; the head slot drives the
// completion outputs directly.
module mem_resp_pipe
  import tagged_mem_responder_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  mem_tag_t    push_tag,
  input  logic [63:0] push_data,
  output resp_slot_t  head
);

  resp_slot_t slots [LATENCY];

  // Empty slots carry all-zero tag and data so the head needs no output mask.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < LATENCY; k++) slots[k] <= '0;
    end else begin
      slots[0] <= push ? resp_slot_t'{valid: 1'b1, tag: push_tag, data: push_data} : '0;
      for (int k = 1; k < LATENCY; k++) slots[k] <= slots[k-1];
    end
  end

  assign head = slots[LATENCY-1];

endmodule

// File: rtl/tagged_mem_responder.sv
// Tagged memory responder: word storage, accept logic, tag and outstanding-load
// counters. Build macro MEM_ALIGN_CHECK_EN rejects non-8-byte-aligned addresses.
module tagged_mem_responder
  import tagged_mem_responder_pkg::*;
#(
  parameter int MEM_WORDS       = 8192,
  parameter int ADDR_BITS       = 13,
  parameter int LATENCY         = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  proc2mem_command,
  input  logic [63:0] proc2mem_addr,
  input  logic [63:0] proc2mem_data,
  output logic [3:0]  mem2proc_response,
  output logic [63:0] mem2proc_data,
  output logic [3:0]  mem2proc_tag
);

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

  logic [63:0]          mem [MEM_WORDS];
  mem_tag_t             next_tag;
  logic [3:0]           outstanding;
  logic [ADDR_BITS-1:0] word_idx;
  logic                 is_load;
  logic                 is_store;
  logic                 in_range;
  logic                 align_ok;
  logic                 accept;
  logic                 load_push;
  logic                 retire;
  resp_slot_t           head;

  assign word_idx = proc2mem_addr[ADDR_BITS+2:3];
  assign is_load  = (proc2mem_command == BUS_LOAD);
  assign is_store = (proc2mem_command == BUS_STORE);
  assign in_range = (proc2mem_addr[63:ADDR_BITS+3] == '0);
  assign align_ok = !(ALIGN_CHECK && (proc2mem_addr[2:0] != 3'b000));

  // Limit is checked against the registered count, so a retiring slot only
  // frees capacity from the following cycle.
  assign accept = reset && in_range && align_ok &&
                  (is_store || (is_load && (outstanding < MAX_OUT)));

  assign load_push         = accept && is_load;
  assign retire            = head.valid;
  assign mem2proc_response = accept ? next_tag : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      next_tag    <= mem_tag_t'(1);
      outstanding <= '0;
    end else begin
      if (accept) next_tag <= tag_inc(next_tag);
      case ({load_push, retire})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Storage is deliberately outside reset so preloaded contents persist.
  always_ff @(posedge clock) begin
    if (accept && is_store) mem[word_idx] <= proc2mem_data;
  end

  mem_resp_pipe #(
    .LATENCY (LATENCY)
  ) u_pipe (
    .clock     (clock),
    .reset     (reset),
    .push      (load_push),
    .push_tag  (next_tag),
    .push_data (mem[word_idx]),
    .head      (head)
  );

  assign mem2proc_tag  = head.tag;
  assign mem2proc_data = head.data;

endmodule
